class_sum_argmax: RTL and testbench

Downstream consumer of the clause-weight lookup stage. Takes one beat per (class, clause) with the clause fire bit and that clause's signed 9-bit weight. Accumulates a signed class sum per class, then runs a sequential argmax. Presents the predicted class and its winning sum to the result/AXI wrapper through a valid/ready handshake.

---
 rtl/class_sum_argmax_pkg.sv | 19 +
 rtl/class_sum_argmax_if.sv | 33 +++
 rtl/class_sum_argmax_argmax_seq.sv | 51 +++++
 rtl/class_sum_argmax.sv | 110 +++++++++++
 tb/tb_class_sum_argmax.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/class_sum_argmax_pkg.sv
// Shared definitions for the class-sum / argmax stage and the upstream weight lookup.
// Holds the controller state encoding, the weight width and the class-sum width rule.
package class_sum_argmax_pkg;

    localparam int WEIGHT_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ARGMAX,
        DONE
    } state_t;

    // One sign bit of headroom above weight * CLAUSEN, so a class sum never overflows.
    function automatic int sum_width(input int clausen);
        return WEIGHT_W + $clog2(clausen) + 1;
    endfunction

endpackage

// File: rtl/class_sum_argmax_if.sv
// Beat input, counter feedback and result handshake of class_sum_argmax.
// The master side is upstream/consumer logic; the slave side is the accumulator.
interface class_sum_argmax_if import class_sum_argmax_pkg::*; #(
    parameter int CLAUSEN = 10,
    parameter int NCLASS  = 2
) ();
    localparam int SUMW = sum_width(CLAUSEN);
    localparam int CW   = $clog2(CLAUSEN) + 1;
    localparam int KW   = $clog2(NCLASS) + 1;

    logic                       start;
    logic                       in_valid;
    logic                       in_ready;
    logic                       clause_fire;
    logic signed [WEIGHT_W-1:0] weight;
    logic [CW-1:0]              clause_no;
    logic [KW-1:0]              class_no;
    logic                       busy;
    logic                       result_valid;
    logic                       result_ready;
    logic [KW-1:0]              pred_class;
    logic signed [SUMW-1:0]     pred_sum;

    modport master (
        output start, in_valid, clause_fire, weight, result_ready,
        input  in_ready, clause_no, class_no, busy, result_valid, pred_class, pred_sum
    );

    modport slave (
        input  start, in_valid, clause_fire, weight, result_ready,
        output in_ready, clause_no, class_no, busy, result_valid, pred_class, pred_sum
    );
endinterface

// File: rtl/class_sum_argmax_argmax_seq.sv
// Sequential signed max-with-index over a vector of sums, one element per cycle.
// done pulses for one cycle once the whole vector has been scanned; ties keep the lowest index.
module argmax_seq #(
    parameter int N    = 2,
    parameter int SUMW = 14,
    parameter int IW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [SUMW-1:0] sums [N],
    output logic                   done,
    output logic [IW-1:0]          max_idx,
    output logic signed [SUMW-1:0] max_val
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic          running;
    logic [AW-1:0] k;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            k       <= '0;
            done    <= 1'b0;
            max_idx <= '0;
            max_val <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                max_val <= sums[0];
                max_idx <= '0;
                k       <= AW'(1);
                running <= (N > 1);
                done    <= (N == 1);
            end else if (running) begin
                if (sums[k] > max_val) begin
                    max_val <= sums[k];
                    max_idx <= IW'(k);
                end
                if (k == AW'(N - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    k <= k + AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/class_sum_argmax.sv
// Accumulates signed clause weights into per-class sums, then reports the argmax class
// and its sum through a valid/ready handshake.
module class_sum_argmax import class_sum_argmax_pkg::*; #(
    parameter int CLAUSEN = 10,
    parameter int NCLASS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    class_sum_argmax_if.slave bus
);
    localparam int SUMW = sum_width(CLAUSEN);
    localparam int CW   = $clog2(CLAUSEN) + 1;
    localparam int KW   = $clog2(NCLASS) + 1;
    localparam int AW   = (NCLASS > 1) ? $clog2(NCLASS) : 1;

    state_t                 state, state_nx;
    logic signed [SUMW-1:0] sums [NCLASS];
    logic [CW-1:0]          clause_cnt;
    logic [KW-1:0]          class_cnt;
    logic signed [SUMW-1:0] addend;
    logic                   beat, last_beat;
    logic                   scan_go, scan_done;
    logic [KW-1:0]          scan_idx;
    logic signed [SUMW-1:0] scan_val;
    logic [KW-1:0]          pred_class_q;
    logic signed [SUMW-1:0] pred_sum_q;

    assign beat      = bus.in_valid && (state == ACCUM);
    assign last_beat = beat && (clause_cnt == CW'(CLAUSEN - 1)) && (class_cnt == KW'(NCLASS - 1));
    assign addend    = bus.clause_fire ? {{(SUMW - WEIGHT_W){bus.weight[WEIGHT_W-1]}}, bus.weight}
                                       : '0;

    always_comb begin
        state_nx         = state;
        bus.in_ready     = 1'b0;
        bus.busy         = 1'b1;
        bus.result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nx = ACCUM;
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (last_beat) state_nx = ARGMAX;
            end
            ARGMAX: begin
                if (scan_done) state_nx = DONE;
            end
            DONE: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The last beat wraps both counters to zero, so they read 0 outside ACCUM without extra muxing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            clause_cnt   <= '0;
            class_cnt    <= '0;
            scan_go      <= 1'b0;
            pred_class_q <= '0;
            pred_sum_q   <= '0;
            for (int unsigned i = 0; i < NCLASS; i++) sums[i] <= '0;
        end else begin
            state   <= state_nx;
            scan_go <= last_beat;
            if (state == IDLE) begin
                clause_cnt <= '0;
                class_cnt  <= '0;
                for (int unsigned i = 0; i < NCLASS; i++) sums[i] <= '0;
            end else if (beat) begin
                sums[class_cnt[AW-1:0]] <= sums[class_cnt[AW-1:0]] + addend;
                if (clause_cnt == CW'(CLAUSEN - 1)) begin
                    clause_cnt <= '0;
                    class_cnt  <= (class_cnt == KW'(NCLASS - 1)) ? '0 : class_cnt + KW'(1);
                end else begin
                    clause_cnt <= clause_cnt + CW'(1);
                end
            end
            if (scan_done) begin
                pred_class_q <= scan_idx;
                pred_sum_q   <= scan_val;
            end
        end
    end

    argmax_seq #(
        .N    (NCLASS),
        .SUMW (SUMW),
        .IW   (KW)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .start   (scan_go),
        .sums    (sums),
        .done    (scan_done),
        .max_idx (scan_idx),
        .max_val (scan_val)
    );

    assign bus.clause_no  = clause_cnt;
    assign bus.class_no   = class_cnt;
    assign bus.pred_class = pred_class_q;
    assign bus.pred_sum   = pred_sum_q;

endmodule

// File: tb/tb_class_sum_argmax.sv
// Randomized self-checking bench for class_sum_argmax against a per-beat weight table model.
module tb_class_sum_argmax;
    import class_sum_argmax_pkg::*;

    localparam int CLAUSEN = 10;
    localparam int NCLASS  = 2;
    localparam int NBEAT   = CLAUSEN * NCLASS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   w [NBEAT];
    bit   f [NBEAT];

    class_sum_argmax_if #(.CLAUSEN(CLAUSEN), .NCLASS(NCLASS)) bus ();

    class_sum_argmax #(.CLAUSEN(CLAUSEN), .NCLASS(NCLASS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int model_sum(input int c);
        int s = 0;
        for (int b = c * CLAUSEN; b < (c + 1) * CLAUSEN; b++) if (f[b]) s += w[b];
        return s;
    endfunction

    function automatic int model_class();
        int best = model_sum(0);
        int idx  = 0;
        for (int c = 1; c < NCLASS; c++) begin
            if (model_sum(c) > best) begin
                best = model_sum(c);
                idx  = c;
            end
        end
        return idx;
    endfunction

    task automatic start_run();
        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.clause_fire = 1'b1; bus.weight = 9'sd100;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0;
    endtask

    // Spurious start pulses during the gaps must be ignored outside IDLE.
    task automatic drive_beats(input int gap_pct, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.start    = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.start = 1'b0; bus.in_valid = 1'b1;
            bus.weight = 9'(w[b]); bus.clause_fire = f[b];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.result_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid: got %0b want 0", bus.result_valid); end
        total++; if (bus.clause_no !== '0 || bus.class_no !== '0) begin bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.clause_no, bus.class_no); end
        total++; if (bus.pred_class !== '0 || bus.pred_sum !== '0) begin bad++; $display("FAIL reset_pred: got %0d/%0d want 0/0", bus.pred_class, bus.pred_sum); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_sum();
        int lat, ps;
        for (int b = 0; b < NBEAT; b++) begin w[b] = (b < CLAUSEN) ? 3 : -2; f[b] = 1'b1; end
        start_run();
        drive_beats(0, NBEAT);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_drop: got %0b want 0", bus.in_ready); end
        wait_result(lat);
        ps = bus.pred_sum;
        total++; if (lat !== NCLASS + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, NCLASS + 1); end
        total++; if (bus.pred_class !== 2'(model_class())) begin bad++; $display("FAIL basic_class: got %0d want %0d", bus.pred_class, model_class()); end
        total++; if (ps !== model_sum(0)) begin bad++; $display("FAIL basic_sum: got %0d want %0d", ps, model_sum(0)); end
        release_result();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_clear: got %0b want 0", bus.result_valid); end
    endtask

    task automatic test_fire_mask();
        int lat, ps;
        for (int b = 0; b < NBEAT; b++) begin
            w[b] = (b < CLAUSEN) ? 100 : 1;
            f[b] = (b >= CLAUSEN) && (b % 2 == 0);
        end
        start_run();
        drive_beats(0, NBEAT);
        wait_result(lat);
        ps = bus.pred_sum;
        total++; if (bus.pred_class !== 2'(model_class())) begin bad++; $display("FAIL mask_class: got %0d want %0d", bus.pred_class, model_class()); end
        total++; if (ps !== model_sum(1)) begin bad++; $display("FAIL mask_sum: got %0d want %0d", ps, model_sum(1)); end
        release_result();
    endtask

    task automatic test_neg_extremes();
        int lat, ps;
        for (int b = 0; b < NBEAT; b++) begin w[b] = -256; f[b] = 1'b1; end
        start_run();
        drive_beats(0, NBEAT);
        wait_result(lat);
        ps = bus.pred_sum;
        total++; if (bus.pred_class !== 2'(model_class())) begin bad++; $display("FAIL neg_tie_class: got %0d want %0d", bus.pred_class, model_class()); end
        total++; if (ps !== model_sum(0)) begin bad++; $display("FAIL neg_sum: got %0d want %0d", ps, model_sum(0)); end
        release_result();
    endtask

    task automatic test_stalls();
        int lat, ps, cls;
        for (int b = 0; b < NBEAT; b++) begin
            w[b] = int'($urandom_range(0, 511)) - 256;
            f[b] = 1'($urandom_range(0, 1));
        end
        start_run();
        drive_beats(40, NBEAT);
        wait_result(lat);
        total++; if (lat !== NCLASS + 1) begin bad++; $display("FAIL stall_latency: got %0d want %0d", lat, NCLASS + 1); end
        cls = model_class();
        for (int i = 0; i < 7; i++) begin
            ps = bus.pred_sum;
            total++;
            if (bus.result_valid !== 1'b1 || bus.pred_class !== 2'(cls) || ps !== model_sum(cls)) begin
                bad++;
                $display("FAIL stall_hold: got v=%0b c=%0d s=%0d want v=1 c=%0d s=%0d", bus.result_valid, bus.pred_class, ps, cls, model_sum(cls));
            end
            @(negedge clk);
        end
        bus.start = 1'b1;
        release_result();
        bus.start = 1'b0;
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_clear: got %0b want 0", bus.result_valid); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL handshake_start_ignored: got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_counter_wrap();
        int lat;
        for (int b = 0; b < NBEAT; b++) begin
            w[b] = int'($urandom_range(0, 511)) - 256;
            f[b] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.weight = 9'sd100; bus.clause_fire = 1'b1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready: got %0b want 0", bus.in_ready); end
        @(negedge clk);
        bus.start = 1'b0;
        for (int b = 0; b < NBEAT; b++) begin
            while ($urandom_range(0, 99) < 30) begin bus.in_valid = 1'b0; @(negedge clk); end
            bus.in_valid = 1'b1; bus.weight = 9'(w[b]); bus.clause_fire = f[b];
            total++;
            if (bus.clause_no !== 5'(b % CLAUSEN) || bus.class_no !== 2'(b / CLAUSEN)) begin
                bad++;
                $display("FAIL wrap_counters beat %0d: got %0d/%0d want %0d/%0d", b, bus.clause_no, bus.class_no, b % CLAUSEN, b / CLAUSEN);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL wrap_in_ready_after_last: got %0b want 0", bus.in_ready); end
        total++; if (bus.clause_no !== '0 || bus.class_no !== '0) begin bad++; $display("FAIL wrap_counters_after: got %0d/%0d want 0/0", bus.clause_no, bus.class_no); end
        wait_result(lat);
        total++; if (bus.pred_class !== 2'(model_class())) begin bad++; $display("FAIL wrap_class: got %0d want %0d", bus.pred_class, model_class()); end
        release_result();
    endtask

    task automatic test_reset_mid();
        int lat, ps;
        for (int b = 0; b < NBEAT; b++) begin w[b] = 255; f[b] = 1'b1; end
        start_run();
        drive_beats(20, 13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.clause_no !== '0 || bus.class_no !== '0) begin
            bad++; $display("FAIL midrst_clear: got busy=%0b %0d/%0d want 0 0/0", bus.busy, bus.clause_no, bus.class_no); end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result: got %0b want 0", bus.result_valid); end
            @(negedge clk);
        end
        for (int b = 0; b < NBEAT; b++) begin
            w[b] = (b < CLAUSEN) ? -int'($urandom_range(1, 256)) : int'($urandom_range(1, 255));
            f[b] = (b == CLAUSEN) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        start_run();
        drive_beats(0, NBEAT);
        wait_result(lat);
        ps = bus.pred_sum;
        total++; if (lat !== NCLASS + 1) begin bad++; $display("FAIL midrst_latency: got %0d want %0d", lat, NCLASS + 1); end
        total++; if (bus.pred_class !== 2'(model_class()) || model_class() !== 1) begin bad++; $display("FAIL midrst_class: got %0d want 1", bus.pred_class); end
        total++; if (ps !== model_sum(1)) begin bad++; $display("FAIL midrst_sum: got %0d want %0d", ps, model_sum(1)); end
        release_result();
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.clause_fire = 1'b0;
        bus.weight = '0; bus.result_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_fire_mask();
        test_neg_extremes();
        test_stalls();
        test_counter_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
